// File: rtl/bcd_calendar_core_if.sv
// Date load/advance request bus and registered calendar outputs of bcd_calendar_core.
interface bcd_calendar_core_if #(
  parameter int unsigned YEAR_DIGITS = 4
);
  localparam int unsigned YW = 4 * YEAR_DIGITS;

  logic          tick;
  logic          en;
  logic          load;
  logic [7:0]    ld_day;
  logic [7:0]    ld_month;
  logic [YW-1:0] ld_year;
  logic [7:0]    day;
  logic [7:0]    month;
  logic [YW-1:0] year;
  logic          leap;
  logic          year_wrap;
  logic          load_err;

  modport master (
    output tick, en, load, ld_day, ld_month, ld_year,
    input  day, month, year, leap, year_wrap, load_err
  );

  modport slave (
    input  tick, en, load, ld_day, ld_month, ld_year,
    output day, month, year, leap, year_wrap, load_err
  );
endinterface

// File: rtl/bcd_calendar_core.sv
// BCD day/month/year calendar advanced by a daily tick, with validated date load.
module bcd_calendar_core #(
  parameter int unsigned YEAR_DIGITS = 4,
  parameter int unsigned GREGORIAN   = 1
) (
  input logic               clk,
  input logic               rst,
  bcd_calendar_core_if.slave bus
);
  localparam int unsigned YW = 4 * YEAR_DIGITS;
  localparam int unsigned LW = 16 + YW;
  localparam int unsigned LD = LW / 4;

  logic [7:0]    day_q, day_d;
  logic [7:0]    month_q, month_d;
  logic [YW-1:0] year_q, year_d;
  logic          leap_q, leap_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;

  logic [YW-1:0] year_inc;
  logic          year_carry;
  logic [LW-1:0] ld_all;
  logic          nib_ok;
  logic          ld_leap;
  logic          ld_ok;

  // Two-digit BCD value divisible by 4: even tens need units 0/4/8, odd tens need 2/6.
  function automatic logic div4_bcd(input logic [3:0] tens, input logic [3:0] units);
    if (tens[0]) return (units == 4'd2) || (units == 4'd6);
    return (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
  endfunction

  function automatic logic leap_of(input logic [YW-1:0] y);
    logic [15:0] y16;
    y16 = 16'(y);
    return div4_bcd(y16[7:4], y16[3:0]) &&
           ((GREGORIAN == 0) || (y16[7:0] != 8'h00) || div4_bcd(y16[15:12], y16[11:8]));
  endfunction

  function automatic logic [7:0] dim_bcd(input logic [7:0] m, input logic lp);
    case (m)
      8'h02:                      return lp ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  function automatic logic [7:0] inc2_bcd(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Ripple-carry BCD year increment; carry out means all-9s wrapped to all-0s.
  always_comb begin
    year_inc   = year_q;
    year_carry = 1'b1;
    for (int i = 0; i < int'(YEAR_DIGITS); i++) begin
      if (year_carry) begin
        if (year_q[4*i +: 4] == 4'd9) begin
          year_inc[4*i +: 4] = 4'd0;
        end else begin
          year_inc[4*i +: 4] = year_q[4*i +: 4] + 4'd1;
          year_carry         = 1'b0;
        end
      end
    end
  end

  // Load validation against the requested year's leap status.
  always_comb begin
    ld_all = {bus.ld_day, bus.ld_month, bus.ld_year};
    nib_ok = 1'b1;
    for (int i = 0; i < int'(LD); i++) begin
      if (ld_all[4*i +: 4] > 4'd9) nib_ok = 1'b0;
    end
    ld_leap = leap_of(bus.ld_year);
    ld_ok   = nib_ok &&
              (bus.ld_month >= 8'h01) && (bus.ld_month <= 8'h12) &&
              (bus.ld_day   >= 8'h01) &&
              (bus.ld_day   <= dim_bcd(bus.ld_month, ld_leap));
  end

  always_comb begin
    day_d   = day_q;
    month_d = month_q;
    year_d  = year_q;
    leap_d  = leap_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.load) begin
      if (ld_ok) begin
        day_d   = bus.ld_day;
        month_d = bus.ld_month;
        year_d  = bus.ld_year;
        leap_d  = ld_leap;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.tick && bus.en) begin
      if (day_q < dim_bcd(month_q, leap_q)) begin
        day_d = inc2_bcd(day_q);
      end else begin
        day_d = 8'h01;
        if (month_q < 8'h12) begin
          month_d = inc2_bcd(month_q);
        end else begin
          month_d = 8'h01;
          year_d  = year_inc;
          leap_d  = leap_of(year_inc);
          wrap_d  = year_carry;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      day_q   <= 8'h01;
      month_q <= 8'h01;
      year_q  <= '0;
      leap_q  <= 1'b1;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      leap_q  <= leap_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.day       = day_q;
  assign bus.month     = month_q;
  assign bus.year      = year_q;
  assign bus.leap      = leap_q;
  assign bus.year_wrap = wrap_q;
  assign bus.load_err  = err_q;
endmodule

// File: tb/tb_bcd_calendar_core.sv
// Directed and random checks of bcd_calendar_core against an integer date model.
module tb_bcd_calendar_core;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  // Integer model of the default instance (GREGORIAN=1, 4 year digits).
  int md, mm, my;
  bit mwrap, merr;

  bcd_calendar_core_if #(.YEAR_DIGITS(4)) a_if ();
  bcd_calendar_core_if #(.YEAR_DIGITS(4)) b_if ();
  bcd_calendar_core_if #(.YEAR_DIGITS(2)) c_if ();

  bcd_calendar_core #(.YEAR_DIGITS(4), .GREGORIAN(1)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  bcd_calendar_core #(.YEAR_DIGITS(4), .GREGORIAN(0)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));
  bcd_calendar_core #(.YEAR_DIGITS(2), .GREGORIAN(1)) dut_c (.clk(clk), .rst(rst), .bus(c_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_leap_m(input int y, input bit greg);
    return (y % 4 == 0) && (!greg || (y % 100 != 0) || (y % 400 == 0));
  endfunction

  function automatic int dim_m(input int m, input int y, input bit greg);
    case (m)
      2:             return is_leap_m(y, greg) ? 29 : 28;
      4, 6, 9, 11:   return 30;
      default:       return 31;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic bit digits_ok(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the default instance, advance the model, compare all outputs.
  task automatic step(input bit r, input bit t, input bit e, input bit l,
                      input logic [7:0] d, input logic [7:0] mo, input logic [15:0] y);
    int dd, mmv, yy;
    logic [15:0] eb;
    @(negedge clk);
    rst = r; a_if.tick = t; a_if.en = e; a_if.load = l;
    a_if.ld_day = d; a_if.ld_month = mo; a_if.ld_year = y;
    mwrap = 1'b0;
    merr  = 1'b0;
    if (r) begin
      md = 1; mm = 1; my = 0;
    end else if (l) begin
      if (digits_ok({d, mo}) && digits_ok(y)) begin
        dd = from_bcd({8'h00, d}); mmv = from_bcd({8'h00, mo}); yy = from_bcd(y);
        if (mmv >= 1 && mmv <= 12 && dd >= 1 && dd <= dim_m(mmv, yy, 1'b1)) begin
          md = dd; mm = mmv; my = yy;
        end else merr = 1'b1;
      end else merr = 1'b1;
    end else if (t && e) begin
      if (md < dim_m(mm, my, 1'b1)) md++;
      else begin
        md = 1;
        if (mm < 12) mm++;
        else begin
          mm = 1;
          if (my == 9999) begin my = 0; mwrap = 1'b1; end
          else my++;
        end
      end
    end
    @(posedge clk);
    #1;
    eb = to_bcd(md);
    chk("day", 32'(a_if.day), 32'(eb[7:0]));
    eb = to_bcd(mm);
    chk("month", 32'(a_if.month), 32'(eb[7:0]));
    chk("year", 32'(a_if.year), 32'(to_bcd(my)));
    chk("leap", 32'(a_if.leap), 32'(is_leap_m(my, 1'b1)));
    chk("year_wrap", 32'(a_if.year_wrap), 32'(mwrap));
    chk("load_err", 32'(a_if.load_err), 32'(merr));
  endtask

  task automatic step_b(input bit t, input bit l, input logic [7:0] d,
                        input logic [7:0] mo, input logic [15:0] y);
    @(negedge clk);
    rst = 1'b0; b_if.tick = t; b_if.en = 1'b1; b_if.load = l;
    b_if.ld_day = d; b_if.ld_month = mo; b_if.ld_year = y;
    @(posedge clk);
    #1;
  endtask

  task automatic step_c(input bit t, input bit l, input logic [7:0] d,
                        input logic [7:0] mo, input logic [7:0] y);
    @(negedge clk);
    rst = 1'b0; c_if.tick = t; c_if.en = 1'b1; c_if.load = l;
    c_if.ld_day = d; c_if.ld_month = mo; c_if.ld_year = y;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int yy, mo, dd;
    logic [15:0] vd, vm, vy;
    bit r, l, t, e;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    a_if.tick = 1'b0; a_if.en = 1'b0; a_if.load = 1'b0;
    a_if.ld_day = '0; a_if.ld_month = '0; a_if.ld_year = '0;
    b_if.tick = 1'b0; b_if.en = 1'b0; b_if.load = 1'b0;
    b_if.ld_day = '0; b_if.ld_month = '0; b_if.ld_year = '0;
    c_if.tick = 1'b0; c_if.en = 1'b0; c_if.load = 1'b0;
    c_if.ld_day = '0; c_if.ld_month = '0; c_if.ld_year = '0;

    step(1, 0, 0, 0, 8'h00, 8'h00, 16'h0000);
    chk("rst_day", 32'(a_if.day), 32'h01);
    chk("rst_leap", 32'(a_if.leap), 32'h1);

    // February end, non-leap and leap years
    step(0, 0, 1, 1, 8'h28, 8'h02, 16'h2023);
    step(0, 1, 1, 0, 8'h00, 8'h00, 16'h0000);
    chk("feb23_month", 32'(a_if.month), 32'h03);
    step(0, 0, 1, 1, 8'h28, 8'h02, 16'h2024);
    step(0, 1, 1, 0, 8'h00, 8'h00, 16'h0000);
    chk("feb24_day", 32'(a_if.day), 32'h29);
    step(0, 1, 1, 0, 8'h00, 8'h00, 16'h0000);
    step(0, 0, 1, 1, 8'h28, 8'h02, 16'h2100);
    step(0, 1, 1, 0, 8'h00, 8'h00, 16'h0000);
    chk("feb2100_month", 32'(a_if.month), 32'h03);
    step(0, 0, 1, 1, 8'h29, 8'h02, 16'h2000);
    chk("feb2000_leap", 32'(a_if.leap), 32'h1);
    step(0, 0, 1, 1, 8'h29, 8'h02, 16'h2100);
    chk("feb2100_err", 32'(a_if.load_err), 32'h1);

    // BCD digit carries within a month and across months
    step(0, 0, 1, 1, 8'h09, 8'h09, 16'h1999);
    step(0, 1, 1, 0, 8'h00, 8'h00, 16'h0000);
    step(0, 0, 1, 1, 8'h30, 8'h09, 16'h1999);
    step(0, 1, 1, 0, 8'h00, 8'h00, 16'h0000);
    chk("sep_to_oct", 32'(a_if.month), 32'h10);

    // Year wrap from all nines
    step(0, 0, 1, 1, 8'h31, 8'h12, 16'h9999);
    step(0, 1, 1, 0, 8'h00, 8'h00, 16'h0000);
    chk("wrap_pulse", 32'(a_if.year_wrap), 32'h1);
    step(0, 0, 1, 0, 8'h00, 8'h00, 16'h0000);
    chk("wrap_clear", 32'(a_if.year_wrap), 32'h0);

    // Rejected loads leave the date alone
    step(0, 0, 1, 1, 8'h15, 8'h06, 16'h2023);
    step(0, 1, 1, 1, 8'h31, 8'h04, 16'h2023);
    chk("apr31_day", 32'(a_if.day), 32'h15);
    step(0, 0, 1, 1, 8'h10, 8'h13, 16'h2023);
    step(0, 0, 1, 1, 8'h1A, 8'h05, 16'h2023);
    step(0, 0, 1, 1, 8'h10, 8'h05, 16'h20A3);
    step(0, 0, 1, 1, 8'h00, 8'h05, 16'h2023);
    step(0, 0, 1, 1, 8'h10, 8'h00, 16'h2023);

    // Disabled ticks, then load with a simultaneous tick
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'h00, 8'h00, 16'h0000);
    chk("en0_day", 32'(a_if.day), 32'h15);
    step(0, 1, 1, 1, 8'h07, 8'h07, 16'h2007);
    chk("ld_tick_day", 32'(a_if.day), 32'h07);

    // A full year of held ticks
    step(0, 0, 1, 1, 8'h01, 8'h01, 16'h2023);
    for (int i = 0; i < 365; i++) step(0, 1, 1, 0, 8'h00, 8'h00, 16'h0000);
    chk("year365", 32'(a_if.year), 32'h2024);
    chk("day365", 32'(a_if.day), 32'h01);
    for (int i = 0; i < 40; i++) step(0, 1, 1, 0, 8'h00, 8'h00, 16'h0000);
    step(1, 1, 1, 1, 8'h05, 8'h05, 16'h2005);
    chk("rst_mid_year", 32'(a_if.year), 32'h0000);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      r = ($urandom_range(0, 63) == 0);
      l = ($urandom_range(0, 7) == 0);
      t = ($urandom_range(0, 3) != 0);
      e = ($urandom_range(0, 7) != 0);
      yy = $urandom_range(0, 9999);
      case ($urandom_range(0, 7))
        0: yy = 9999;
        1: yy = 2000;
        2: yy = 2100;
        default: ;
      endcase
      mo = $urandom_range(1, 12);
      dd = $urandom_range(1, dim_m(mo, yy, 1'b1) + 1);
      if ($urandom_range(0, 1) == 0) dd = dim_m(mo, yy, 1'b1);
      vd = to_bcd(dd); vm = to_bcd(mo); vy = to_bcd(yy);
      if ($urandom_range(0, 15) == 0) vd[7:0] = 8'($urandom);
      if ($urandom_range(0, 15) == 0) vm[7:0] = 8'($urandom);
      step(r, t, e, l, vd[7:0], vm[7:0], vy);
    end

    // Julian-only leap rule
    a_if.load = 1'b0; a_if.tick = 1'b0;
    step_b(0, 1, 8'h29, 8'h02, 16'h2100);
    chk("j_day", 32'(b_if.day), 32'h29);
    chk("j_leap", 32'(b_if.leap), 32'h1);
    chk("j_err", 32'(b_if.load_err), 32'h0);
    step_b(1, 0, 8'h00, 8'h00, 16'h0000);
    chk("j_tick_month", 32'(b_if.month), 32'h03);
    step_b(0, 1, 8'h01, 8'h01, 16'h1901);
    chk("j_leap1901", 32'(b_if.leap), 32'h0);

    // Two-digit year wrap
    step_c(0, 1, 8'h31, 8'h12, 8'h99);
    chk("c_year99", 32'(c_if.year), 32'h99);
    step_c(1, 0, 8'h00, 8'h00, 8'h00);
    chk("c_year00", 32'(c_if.year), 32'h00);
    chk("c_day", 32'(c_if.day), 32'h01);
    chk("c_wrap", 32'(c_if.year_wrap), 32'h1);
    chk("c_leap", 32'(c_if.leap), 32'h1);
    step_c(0, 0, 8'h00, 8'h00, 8'h00);
    chk("c_wrap_clear", 32'(c_if.year_wrap), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_calendar_core.md
BCD_CALENDAR_CORE -- requirements
Module: bcd_calendar_core

Interface
REQ-001 Parameter YEAR_DIGITS, default 4, number of BCD year digits; legal range 2-4.
REQ-002 Parameter GREGORIAN, default 1; 1 = full 100/400 leap rule, 0 = divisible-by-4 only.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tick  input  1  day-advance pulse (carry from time-of-day chain at 23:59:59.99).
REQ-006 en  input  1  run enable; tick honoured only when en=1.
REQ-007 load  input  1  one-cycle request to load date from ld_* inputs.
REQ-008 ld_day  input  8  BCD day {tens,units}.
REQ-009 ld_month  input  8  BCD month {tens,units}.
REQ-010 ld_year  input  4*YEAR_DIGITS  BCD year, most significant digit first.
REQ-011 day  output  8  current BCD day, range 01-31.
REQ-012 month  output  8  current BCD month, range 01-12 (1-based).
REQ-013 year  output  4*YEAR_DIGITS  current BCD year.
REQ-014 leap  output  1  registered flag, 1 when current year is leap.
REQ-015 year_wrap  output  1  one-cycle pulse when year rolls from all-9s to all-0s.
REQ-016 load_err  output  1  one-cycle pulse when a load request is rejected.

Function
REQ-017 Priority per cycle SHALL be rst > load > (tick & en); a load and an enabled tick in the same cycle SHALL apply the load only, with the tick discarded.
REQ-018 All outputs SHALL be registered; an accepted tick or load SHALL be visible on outputs at the following rising edge (1-cycle latency).
REQ-019 Days-in-month: 31 for months 01,03,05,07,08,10,12; 30 for 04,06,09,11; 02 gives 29 if leap, else 28.
REQ-020 Leap, with Y = decimal value of year: Y mod 4 = 0 AND (GREGORIAN=0 OR Y mod 100 != 0 OR Y mod 400 = 0); computed directly on BCD digits, no binary conversion.
REQ-021 Accepted tick with day < days-in-month: day += 1, BCD-correct (09->10, 19->20, 29->30).
REQ-022 Accepted tick on last day, month < 12: day <= 01, month += 1 (09->10).
REQ-023 Accepted tick on last day of month 12: day <= 01, month <= 01, year += 1 with BCD ripple carry across all YEAR_DIGITS digits.
REQ-024 Year increment from all-9s SHALL wrap to all-0s and assert year_wrap for exactly that update cycle; year_wrap = 0 in all other cycles.
REQ-025 Load SHALL be accepted only if every ld_* nibble is <= 9, month is 01-12, and day is 01..days-in-month(ld_month, ld_year); the leap test uses ld_year, not the current year.
REQ-026 Rejected load: day/month/year/leap SHALL be unchanged; load_err = 1 for one cycle; the same-cycle tick is still discarded.
REQ-027 leap SHALL always reflect the year currently held in the registered outputs, updating in the same cycle as year.
REQ-028 tick with en=0 SHALL be ignored with no state change; ticks are not queued.
REQ-029 tick held high for N cycles with en=1 SHALL advance N days (level-per-cycle, no edge detection).

Reset
REQ-030 On rst=1 at a clock edge: day=01, month=01, year=all zeros, leap=1 (year 0 is leap in both modes), year_wrap=0, load_err=0.
REQ-031 rst asserted in the same cycle as load or tick SHALL override both; the request is lost.

Verification
REQ-032 Load 28/02/2023, tick -> 01/03/2023, leap=0; load 28/02/2024, tick -> 29/02/2024, leap=1.
REQ-033 GREGORIAN=1: load 28/02/2100, tick -> 01/03/2100; load 29/02/2000 -> accepted, leap=1; GREGORIAN=0: load 29/02/2100 -> accepted.
REQ-034 Load 31/12/9999, tick -> 01/01/0000, year_wrap=1 for one cycle, then 0; YEAR_DIGITS=2: 31/12/99 -> 01/01/00, year_wrap=1.
REQ-035 Load 31/04/2023 -> load_err=1 one cycle, date unchanged; load month 13 or nibble 0xA -> load_err=1, date unchanged.
REQ-036 en=0 with tick=1 for 5 cycles -> no change; load and tick in the same cycle -> loaded date, not incremented.
REQ-037 tick=1 held 365 cycles from 01/01/2023 -> 01/01/2024; rst mid-sequence -> 01/01/0000 at the next edge.
